// File: rtl/uart_tx_fifo_if.sv
// Byte-stream producer interface for the buffered UART transmitter.
// A byte moves on every rising clk edge where tx_valid & tx_ready are both high;
// tx_data is only meaningful while tx_valid is high, and tx_ready never depends on tx_valid.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: DEPTH-entry byte FIFO feeding a registered serial shifter.
// Frames are emitted back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int frequency = 1600,
  parameter int baudrate  = 10,
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          bus,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [1:0]             state_o
);

  localparam int DIV    = frequency / baudrate;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [7:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;
  logic [FCNT_W-1:0]   count_d;
  logic [CNT_W-1:0]    baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                tx_q;

  logic push;
  logic pop;
  logic bit_end;
  logic non_empty;

  // Full refuses a push even when the shifter pops in the same cycle.
  always_comb begin
    non_empty = (count_q != '0);
    bit_end   = (baud_q == BAUD_LAST);
    push      = bus.tx_valid && (count_q != FIFO_FULL);
    pop       = 1'b0;
    if (state_q == IDLE) begin
      pop = non_empty;
    end else if ((state_q == STOP) && bit_end && (bit_q == STOP_LAST)) begin
      pop = non_empty;
    end
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // bit_q indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                shift_q <= mem_q[rd_ptr_q];
                tx_q    <= 1'b0;
                state_q <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = (count_q != FIFO_FULL);
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE) || non_empty;
  assign fifo_count   = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial line decoder scores frames from the 1-stop-bit instance
// against an expected byte queue; a second instance covers 2 stop bits.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DIV  = 160;
  localparam int HALF = DIV / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if bus1();
  uart_tx_fifo_if bus2();
  logic       tx1, busy1, tx2, busy2;
  logic [2:0] cnt1, cnt2;
  logic [1:0] st1, st2;

  uart_tx_fifo #(.frequency(1600), .baudrate(10), .DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .tx(tx1), .busy(busy1),
    .fifo_count(cnt1), .state_o(st1)
  );

  uart_tx_fifo #(.frequency(1600), .baudrate(10), .DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .tx(tx2), .busy(busy2),
    .fifo_count(cnt2), .state_o(st2)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  logic       mon_on = 1'b0;
  int         mon_n  = 0;
  logic [3:0] mon_k  = '0;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp  = '0;

  // Line decoder: samples the middle of every bit of each frame seen on tx1.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx1 === 1'b0) begin
        mon_on = 1'b1;
        mon_n  = 0;
        mon_k  = '0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_n++;
      if (mon_n == HALF) begin
        checks++;
        if (tx1 !== 1'b0) begin
          failures++;
          $display("FAIL mon_start_bit got=%b want=0 at cyc=%0d", tx1, cyc);
        end
      end else if (mon_k < 4'd8 && mon_n == HALF + DIV * (int'(mon_k) + 1)) begin
        mon_byte[mon_k[2:0]] = tx1;
        mon_k++;
      end else if (mon_n == HALF + 9 * DIV) begin
        checks++;
        if (tx1 !== 1'b1) begin
          failures++;
          $display("FAIL mon_stop_bit got=%b want=1 at cyc=%0d", tx1, cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected_frame got=%h want=none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin
            failures++;
            $display("FAIL mon_byte got=%h want=%h", mon_byte, mon_exp);
          end
        end
        mon_on = 1'b0;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00;
    bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy1); end
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", cnt1); end
    checks++; if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus1.tx_ready); end
    checks++; if (st1 !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", st1); end
    checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL reset_tx2 got=%b want=1", tx2); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int s;
    int n;
    start_q.delete();
    @(negedge clk);
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'h53; exp_q.push_back(8'h53);
    @(negedge clk);
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'($urandom_range(0, 255));
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL single_pre_tx got=%b want=1", tx1); end
    checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL single_count got=%0d want=1", cnt1); end
    @(negedge clk);
    checks++; if (tx1 !== 1'b0) begin failures++; $display("FAIL single_latency got=%b want=0", tx1); end
    checks++; if (st1 !== 2'd1) begin failures++; $display("FAIL single_state got=%0d want=1", st1); end
    s = cyc;
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      @(negedge clk);
      bus1.tx_data = 8'($urandom_range(0, 255));
      n++;
    end
    checks++; if (cyc - s !== 1600) begin failures++; $display("FAIL single_busy_len got=%0d want=1600", cyc - s); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL single_drain got=%0d want=0", exp_q.size()); end
    checks++; if (start_q.size() !== 1) begin failures++; $display("FAIL single_frames got=%0d want=1", start_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int n;
    bytes[0] = 8'h53; bytes[1] = 8'hCD; bytes[2] = 8'hAB;
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b want=1", i, bus1.tx_ready); end
      bus1.tx_valid = 1'b1; bus1.tx_data = bytes[i]; exp_q.push_back(bytes[i]);
    end
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    checks++; if (cnt1 !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d want=2", cnt1); end
    n = 0;
    while (busy1 === 1'b1 && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (start_q.size() !== 3) begin
      failures++; $display("FAIL b2b_frames got=%0d want=3", start_q.size());
    end else begin
      checks++; if (start_q[1] - start_q[0] !== 1600) begin failures++; $display("FAIL b2b_gap1 got=%0d want=1600", start_q[1] - start_q[0]); end
      checks++; if (start_q[2] - start_q[1] !== 1600) begin failures++; $display("FAIL b2b_gap2 got=%0d want=1600", start_q[2] - start_q[1]); end
      checks++; if (cyc - start_q[0] !== 4800) begin failures++; $display("FAIL b2b_total got=%0d want=4800", cyc - start_q[0]); end
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_hold();
    logic       exp_rdy [8];
    logic [2:0] exp_cnt [8];
    logic [7:0] b;
    int n;
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    start_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      bus1.tx_valid = 1'b1; bus1.tx_data = b;
      checks++; if (bus1.tx_ready !== exp_rdy[i]) begin failures++; $display("FAIL hold_ready%0d got=%b want=%b", i, bus1.tx_ready, exp_rdy[i]); end
      checks++; if (cnt1 !== exp_cnt[i]) begin failures++; $display("FAIL hold_count%0d got=%0d want=%0d", i, cnt1, exp_cnt[i]); end
      if (exp_rdy[i]) exp_q.push_back(b);
    end
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    n = 0;
    while (bus1.tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (start_q.size() < 1) begin
      failures++; $display("FAIL hold_no_frame got=0 want=1");
    end else if (cyc - start_q[0] !== 1600) begin
      failures++; $display("FAIL hold_ready_rise got=%0d want=1600", cyc - start_q[0]);
    end
    checks++; if (cnt1 !== 3'd3) begin failures++; $display("FAIL hold_count_rise got=%0d want=3", cnt1); end
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'hC6; exp_q.push_back(8'hC6);
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    checks++; if (cnt1 !== 3'd4) begin failures++; $display("FAIL hold_sixth got=%0d want=4", cnt1); end
    n = 0;
    while (busy1 === 1'b1 && n < 10000) begin @(negedge clk); n++; end
    checks++; if (start_q.size() !== 6) begin failures++; $display("FAIL hold_frames got=%0d want=6", start_q.size()); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL hold_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [3];
    int n;
    int s;
    int lows;
    bytes[0] = 8'hAB; bytes[1] = 8'h11; bytes[2] = 8'h22;
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.tx_valid = 1'b1; bus1.tx_data = bytes[i]; exp_q.push_back(bytes[i]);
    end
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    n = 0;
    while (start_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    s = (start_q.size() > 0) ? start_q[0] : cyc;
    n = 0;
    while (cyc < s + 700 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (cnt1 !== 3'd2) begin failures++; $display("FAIL rstmid_queued got=%0d want=2", cnt1); end
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL rstmid_bit3 got=%b want=1", tx1); end
    rst = 1'b0;
    #1;
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b want=1", tx1); end
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d want=0", cnt1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy1); end
    checks++; if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b want=1", bus1.tx_ready); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus1.tx_data = 8'($urandom_range(0, 255));
      if (tx1 !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL rstmid_no_frame got=%0d want=0", lows); end
    checks++; if (start_q.size() !== 1) begin failures++; $display("FAIL rstmid_frames got=%0d want=1", start_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int n;
    start_q.delete();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      checks++; if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL rand_ready%0d got=%b want=1", i, bus1.tx_ready); end
      bus1.tx_valid = 1'b1; bus1.tx_data = b; exp_q.push_back(b);
      @(negedge clk);
      bus1.tx_valid = 1'b0; bus1.tx_data = 8'($urandom_range(0, 255));
    end
    n = 0;
    while (busy1 === 1'b1 && n < 8000) begin @(negedge clk); n++; end
    checks++; if (start_q.size() !== 4) begin failures++; $display("FAIL rand_frames got=%0d want=4", start_q.size()); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stop2();
    int n;
    int s;
    int r1;
    int f2;
    int r2;
    @(negedge clk);
    bus2.tx_valid = 1'b1; bus2.tx_data = 8'hFF;
    @(negedge clk);
    bus2.tx_data = 8'h00;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    n = 0;
    while (tx2 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    s = cyc;
    n = 0;
    while (tx2 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    r1 = cyc;
    checks++; if (r1 - s !== 160) begin failures++; $display("FAIL stop2_start_len got=%0d want=160", r1 - s); end
    n = 0;
    while (tx2 !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    f2 = cyc;
    checks++; if (f2 - s !== 1760) begin failures++; $display("FAIL stop2_next_start got=%0d want=1760", f2 - s); end
    n = 0;
    while (tx2 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    r2 = cyc;
    checks++; if (r2 - f2 !== 1440) begin failures++; $display("FAIL stop2_zero_frame got=%0d want=1440", r2 - f2); end
    n = 0;
    while (busy2 === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (cyc - r2 !== 320) begin failures++; $display("FAIL stop2_stop_len got=%0d want=320", cyc - r2); end
    checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL stop2_idle_tx got=%b want=1", tx2); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    test_stop2();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
